// File: rtl/dma_fifo_device.sv
// -----------------------------------------------------------------------------
// dma_fifo_device
//   Memory-mapped DMA peripheral on the 16-bit per_* bus. A 2**FIFO_AW word
//   FIFO sits between the CPU (DATA register) and the DMA controller
//   (dev_in / dev_out with the dma_ack / dev_ack handshake).
//     RD mode (CONFIG[2]=1): DMA pushes memory words, CPU pops them via DATA.
//     WR mode (CONFIG[2]=0): CPU pushes via DATA, DMA pops them to memory.
//   Sticky END_OP / OVF / UNF flags, a transfer counter, abort and an
//   end-of-operation interrupt are provided.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   per_addr/din/en/we  peripheral bus (word address, write data, enable,
//                       byte write enables - any set bit means write)
//   per_dout            combinational read data, 0 when not selected
//   dev_in              word from the DMA controller (RD mode)
//   dma_ack             DMA controller word strobe
//   dma_end_flag        DMA controller end-of-operation pulse
//   dev_ack             device can take/give a word this cycle
//   dev_out             FIFO head towards the DMA controller (WR mode)
//   dma_rqst            operation request (CONFIG[0])
//   dma_rd_wr           1 = memory to device, 0 = device to memory
//   dma_start_address   START_ADDR register
//   dma_num_words       N_WORDS register
//   irq                 IRQ_EN & END_OP
//
// Register map (byte offset): 0x0 START_ADDR, 0x2 N_WORDS, 0x4 CONFIG,
//   0x6 STATUS, 0x8 DATA, 0xA XFER_CNT, 0xC/0xE read as zero.
// -----------------------------------------------------------------------------
module dma_fifo_device #(
   parameter logic [14:0] BASE_ADDR = 15'h0100,
   parameter int          DEC_WD    = 4,
   parameter int          FIFO_AW   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout,
   input  logic [15:0] dev_in,
   input  logic        dma_ack,
   input  logic        dma_end_flag,
   output logic        dev_ack,
   output logic [15:0] dev_out,
   output logic        dma_rqst,
   output logic        dma_rd_wr,
   output logic [15:0] dma_start_address,
   output logic [15:0] dma_num_words,
   output logic        irq
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam int IW    = DEC_WD - 1;

   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   localparam logic [IW-1:0] REG_START_ADDR = IW'(0);
   localparam logic [IW-1:0] REG_N_WORDS    = IW'(1);
   localparam logic [IW-1:0] REG_CONFIG     = IW'(2);
   localparam logic [IW-1:0] REG_STATUS     = IW'(3);
   localparam logic [IW-1:0] REG_DATA       = IW'(4);
   localparam logic [IW-1:0] REG_XFER_CNT   = IW'(5);

   // Registers
   logic [15:0]        start_addr_r;
   logic [15:0]        n_words_r;
   logic               start_r;
   logic               rd_wr_r;
   logic               irq_en_r;
   logic               end_op_r;
   logic               ovf_r;
   logic               unf_r;
   logic [15:0]        xfer_cnt_r;
   logic [15:0]        mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r;
   logic [FIFO_AW-1:0] rd_ptr_r;
   logic [CW-1:0]      count_r;

   // Decode and datapath signals
   logic               sel_s;
   logic               wr_s;
   logic               rd_s;
   logic [IW-1:0]      reg_idx_s;
   logic               cfg_wr_s;
   logic               status_wr_s;
   logic               data_wr_s;
   logic               data_rd_s;
   logic               empty_s;
   logic               full_s;
   logic               dev_ack_s;
   logic               xfer_s;
   logic               push_s;
   logic               pop_s;
   logic [15:0]        push_data_s;
   logic               clr_s;
   logic               ovf_set_s;
   logic               unf_set_s;
   logic               start_rise_s;
   logic [15:0]        head_s;
   logic [15:0]        status_s;
   logic [15:0]        rdata_s;

   assign sel_s       = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
   assign wr_s        = sel_s & (|per_we);
   assign rd_s        = sel_s & ~(|per_we);
   assign reg_idx_s   = per_addr[IW-1:0];
   assign cfg_wr_s    = wr_s & (reg_idx_s == REG_CONFIG);
   assign status_wr_s = wr_s & (reg_idx_s == REG_STATUS);
   assign data_wr_s   = wr_s & (reg_idx_s == REG_DATA);
   assign data_rd_s   = rd_s & (reg_idx_s == REG_DATA);

   // FULL/EMPTY come straight from the registered count, so a pop this cycle
   // cannot free a slot for a push in the same cycle.
   assign empty_s = (count_r == {CW{1'b0}});
   assign full_s  = (count_r == DEPTH_CNT);
   assign head_s  = mem_r[rd_ptr_r];

   assign dev_ack_s = start_r & (rd_wr_r ? ~full_s : ~empty_s);
   assign xfer_s    = dma_ack & dev_ack_s;

   // RD mode: DMA pushes, CPU pops. WR mode: CPU pushes, DMA pops.
   assign push_s      = rd_wr_r ? xfer_s : (data_wr_s & ~full_s);
   assign pop_s       = rd_wr_r ? (data_rd_s & ~empty_s) : xfer_s;
   assign push_data_s = rd_wr_r ? dev_in : per_din;
   assign clr_s       = cfg_wr_s & per_din[4];
   assign ovf_set_s   = ~rd_wr_r & data_wr_s & full_s;
   assign unf_set_s   = rd_wr_r & data_rd_s & empty_s;

   // A start request coinciding with end-of-operation is discarded.
   assign start_rise_s = cfg_wr_s & ~start_r & per_din[0] & ~dma_end_flag;

   // FIFO storage write port; contents need no reset since COUNT gates use.
   always_ff @(posedge clk) begin
      if (push_s & ~clr_s & ~reset) begin
         mem_r[wr_ptr_r] <= push_data_s;
      end
   end

   // FIFO pointers and occupancy; clear has priority over push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {FIFO_AW{1'b0}};
         rd_ptr_r <= {FIFO_AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (clr_s) begin
         wr_ptr_r <= {FIFO_AW{1'b0}};
         rd_ptr_r <= {FIFO_AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Control/config registers, sticky flags and the transfer counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_addr_r <= 16'h0000;
         n_words_r    <= 16'h0000;
         start_r      <= 1'b0;
         rd_wr_r      <= 1'b0;
         irq_en_r     <= 1'b0;
         end_op_r     <= 1'b0;
         ovf_r        <= 1'b0;
         unf_r        <= 1'b0;
         xfer_cnt_r   <= 16'h0000;
      end else begin
         if (wr_s & (reg_idx_s == REG_START_ADDR)) begin
            start_addr_r <= per_din;
         end
         if (wr_s & (reg_idx_s == REG_N_WORDS)) begin
            n_words_r <= per_din;
         end

         // End of operation overrides any CPU write to START.
         if (dma_end_flag) begin
            start_r <= 1'b0;
         end else if (cfg_wr_s) begin
            start_r <= per_din[0];
         end

         // Direction and IRQ enable are frozen while an operation runs.
         if (cfg_wr_s & ~start_r) begin
            rd_wr_r  <= per_din[2];
            irq_en_r <= per_din[3];
         end

         if (start_rise_s) begin
            xfer_cnt_r <= 16'h0000;
         end else if (xfer_s) begin
            xfer_cnt_r <= xfer_cnt_r + 16'h0001;
         end

         // Setting a flag wins over a same-cycle write-one-to-clear.
         if (dma_end_flag) begin
            end_op_r <= 1'b1;
         end else if (start_rise_s | (status_wr_s & per_din[15])) begin
            end_op_r <= 1'b0;
         end

         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end else if (status_wr_s & per_din[14]) begin
            ovf_r <= 1'b0;
         end

         if (unf_set_s) begin
            unf_r <= 1'b1;
         end else if (status_wr_s & per_din[13]) begin
            unf_r <= 1'b0;
         end
      end
   end

   // STATUS word assembly.
   always_comb begin
      status_s            = 16'h0000;
      status_s[15]        = end_op_r;
      status_s[14]        = ovf_r;
      status_s[13]        = unf_r;
      status_s[12]        = full_s;
      status_s[11]        = empty_s;
      status_s[FIFO_AW:0] = count_r;
   end

   // Combinational read mux; zero whenever the block is not being read.
   always_comb begin
      rdata_s = 16'h0000;
      if (rd_s) begin
         case (reg_idx_s)
            REG_START_ADDR: rdata_s = start_addr_r;
            REG_N_WORDS:    rdata_s = n_words_r;
            REG_CONFIG:     rdata_s = {12'h000, irq_en_r, rd_wr_r, 1'b0, start_r};
            REG_STATUS:     rdata_s = status_s;
            REG_DATA:       rdata_s = (rd_wr_r & ~empty_s) ? head_s : 16'h0000;
            REG_XFER_CNT:   rdata_s = xfer_cnt_r;
            default:        rdata_s = 16'h0000;
         endcase
      end else begin
         rdata_s = 16'h0000;
      end
   end

   assign per_dout          = rdata_s;
   assign dev_ack           = dev_ack_s;
   assign dev_out           = (~rd_wr_r & start_r & ~empty_s) ? head_s : 16'h0000;
   assign dma_rqst          = start_r;
   assign dma_rd_wr         = rd_wr_r;
   assign dma_start_address = start_addr_r;
   assign dma_num_words     = n_words_r;
   assign irq               = irq_en_r & end_op_r;

endmodule

// File: tb/tb_dma_fifo_device.sv
module tb_dma_fifo_device;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;
   logic [15:0] dev_in;
   logic        dma_ack;
   logic        dma_end_flag;
   logic        dev_ack;
   logic [15:0] dev_out;
   logic        dma_rqst;
   logic        dma_rd_wr;
   logic [15:0] dma_start_address;
   logic [15:0] dma_num_words;
   logic        irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dma_fifo_device dut (
      .clk(clk), .reset(reset),
      .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
      .per_dout(per_dout),
      .dev_in(dev_in), .dma_ack(dma_ack), .dma_end_flag(dma_end_flag),
      .dev_ack(dev_ack), .dev_out(dev_out),
      .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
      .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
      .irq(irq)
   );

   // Reference model: FIFO as a queue, depth 8, base word address 0x0080.
   logic [15:0] m_q[$];
   logic        m_start, m_rdwr, m_irqen, m_endop, m_ovf, m_unf;
   logic [15:0] m_xfer, m_saddr, m_nw;
   logic [15:0] last_dout;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_start = 1'b0; m_rdwr = 1'b0; m_irqen = 1'b0;
      m_endop = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_xfer = 16'h0000; m_saddr = 16'h0000; m_nw = 16'h0000;
   endtask

   function automatic logic m_sel();
      return per_en && (per_addr[13:3] == 11'h010);
   endfunction

   function automatic logic [15:0] m_status();
      logic [15:0] s;
      s = 16'h0000;
      s[15] = m_endop; s[14] = m_ovf; s[13] = m_unf;
      s[12] = (m_q.size() == 8);
      s[11] = (m_q.size() == 0);
      s[3:0] = 4'(m_q.size());
      return s;
   endfunction

   function automatic logic m_dev_ack();
      if (!m_start) return 1'b0;
      return m_rdwr ? (m_q.size() < 8) : (m_q.size() > 0);
   endfunction

   function automatic logic [15:0] m_dev_out();
      if (!m_rdwr && m_start && m_q.size() > 0) return m_q[0];
      return 16'h0000;
   endfunction

   function automatic logic [15:0] m_dout();
      if (!m_sel() || per_we != 2'b00) return 16'h0000;
      case (per_addr[2:0])
         3'd0: return m_saddr;
         3'd1: return m_nw;
         3'd2: return {12'h000, m_irqen, m_rdwr, 1'b0, m_start};
         3'd3: return m_status();
         3'd4: return (m_rdwr && m_q.size() > 0) ? m_q[0] : 16'h0000;
         3'd5: return m_xfer;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_step();
      logic wr, rd, empty, full, xfer, start_rise, cfg;
      logic [2:0] idx;
      if (reset) begin
         model_clear();
         return;
      end
      wr    = m_sel() && per_we != 2'b00;
      rd    = m_sel() && per_we == 2'b00;
      idx   = per_addr[2:0];
      empty = (m_q.size() == 0);
      full  = (m_q.size() == 8);
      xfer  = dma_ack && m_dev_ack();
      cfg   = wr && idx == 3'd2;
      start_rise = cfg && !m_start && per_din[0] && !dma_end_flag;
      if (cfg && per_din[4]) m_q.delete();
      else if (m_rdwr) begin
         if (rd && idx == 3'd4 && !empty) void'(m_q.pop_front());
         if (xfer) m_q.push_back(dev_in);
      end else begin
         if (xfer) void'(m_q.pop_front());
         if (wr && idx == 3'd4 && !full) m_q.push_back(per_din);
      end
      if (wr && idx == 3'd3) begin
         if (per_din[15]) m_endop = 1'b0;
         if (per_din[14]) m_ovf = 1'b0;
         if (per_din[13]) m_unf = 1'b0;
      end
      if (m_rdwr && rd && idx == 3'd4 && empty) m_unf = 1'b1;
      if (!m_rdwr && wr && idx == 3'd4 && full) m_ovf = 1'b1;
      if (start_rise) begin
         m_endop = 1'b0;
         m_xfer  = 16'h0000;
      end else if (xfer) m_xfer = m_xfer + 16'h0001;
      if (dma_end_flag) m_endop = 1'b1;
      if (wr && idx == 3'd0) m_saddr = per_din;
      if (wr && idx == 3'd1) m_nw = per_din;
      if (cfg && !m_start) begin
         m_rdwr  = per_din[2];
         m_irqen = per_din[3];
      end
      if (dma_end_flag) m_start = 1'b0;
      else if (cfg) m_start = per_din[0];
   endtask

   // One clock: compare all outputs with the model, advance both, idle inputs.
   task automatic cyc();
      #1;
      chk("dev_ack",   {15'd0, dev_ack},   {15'd0, m_dev_ack()});
      chk("dev_out",   dev_out,            m_dev_out());
      chk("per_dout",  per_dout,           m_dout());
      chk("dma_rqst",  {15'd0, dma_rqst},  {15'd0, m_start});
      chk("dma_rd_wr", {15'd0, dma_rd_wr}, {15'd0, m_rdwr});
      chk("irq",       {15'd0, irq},       {15'd0, m_irqen & m_endop});
      chk("start_addr", dma_start_address, m_saddr);
      chk("n_words",   dma_num_words,      m_nw);
      last_dout = per_dout;
      model_step();
      @(posedge clk);
      #1;
      per_en = 1'b0; per_we = 2'b00; dma_ack = 1'b0; dma_end_flag = 1'b0; reset = 1'b0;
   endtask

   task automatic bus_wr(input logic [2:0] idx, input logic [15:0] data);
      per_en = 1'b1; per_we = 2'b11; per_addr = 14'h0080 + {11'd0, idx}; per_din = data;
      cyc();
   endtask

   task automatic bus_rd(input logic [2:0] idx, output logic [15:0] v);
      per_en = 1'b1; per_we = 2'b00; per_addr = 14'h0080 + {11'd0, idx};
      cyc();
      v = last_dout;
   endtask

   task automatic dma_word(input logic [15:0] data);
      dev_in = data; dma_ack = 1'b1;
      cyc();
   endtask

   initial begin
      logic [15:0] v;
      logic [15:0] wr_words [3];
      wr_words[0] = 16'hA0A1; wr_words[1] = 16'hB0B1; wr_words[2] = 16'hC0C1;
      reset = 1'b1; per_en = 1'b0; per_we = 2'b00; per_addr = 14'h0000; per_din = 16'h0000;
      dev_in = 16'h0000; dma_ack = 1'b0; dma_end_flag = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      #1;
      chk("rst_dma_rqst", {15'd0, dma_rqst}, 16'h0000);
      chk("rst_rd_wr",    {15'd0, dma_rd_wr}, 16'h0000);
      chk("rst_dev_ack",  {15'd0, dev_ack}, 16'h0000);
      chk("rst_dev_out",  dev_out, 16'h0000);
      chk("rst_irq",      {15'd0, irq}, 16'h0000);
      chk("rst_per_dout", per_dout, 16'h0000);
      bus_rd(3'd3, v); chk("rst_status", v, 16'h0800);

      // RD mode: 4 DMA words, drained by CPU in order
      bus_wr(3'd0, 16'h0200);
      bus_wr(3'd1, 16'h0004);
      bus_wr(3'd2, 16'h0005);
      chk("rd_start_addr", dma_start_address, 16'h0200);
      chk("rd_n_words", dma_num_words, 16'h0004);
      for (int k = 1; k <= 4; k++) dma_word(16'h1111 * 16'(k));
      bus_rd(3'd3, v); chk("rd_status_cnt4", v, 16'h0004);
      bus_rd(3'd5, v); chk("rd_xfer_cnt4", v, 16'h0004);
      for (int k = 1; k <= 4; k++) begin
         bus_rd(3'd4, v); chk("rd_data_order", v, 16'h1111 * 16'(k));
      end

      // RD backpressure: 10 strobes, only 8 accepted
      for (int k = 0; k < 10; k++) dma_word(16'h5000 + 16'(k));
      bus_rd(3'd3, v); chk("bp_status_full", v, 16'h1008);
      #1; chk("bp_dev_ack_low", {15'd0, dev_ack}, 16'h0000);
      dev_in = 16'hDEAD; dma_ack = 1'b1;
      bus_rd(3'd4, v); chk("bp_pop_head", v, 16'h5000);
      #1; chk("bp_dev_ack_next", {15'd0, dev_ack}, 16'h0001);
      bus_rd(3'd5, v); chk("bp_xfer_cnt", v, 16'h000C);
      bus_wr(3'd2, 16'h0010);
      bus_rd(3'd3, v); chk("bp_cleared", v, 16'h0800);

      // Errors: underflow in RD, overflow in WR, W1C clear
      bus_rd(3'd4, v); chk("unf_data_zero", v, 16'h0000);
      bus_rd(3'd3, v); chk("unf_flag", v, 16'h2800);
      bus_wr(3'd2, 16'h0000);
      for (int k = 0; k < 9; k++) bus_wr(3'd4, 16'h7000 + 16'(k));
      bus_rd(3'd3, v); chk("ovf_flag_cnt8", v, 16'h7008);
      bus_wr(3'd3, 16'h6000);
      bus_rd(3'd3, v); chk("w1c_clear", v, 16'h1008);
      bus_wr(3'd2, 16'h0010);

      // WR mode: CPU fills, DMA drains in order
      for (int k = 0; k < 3; k++) bus_wr(3'd4, wr_words[k]);
      bus_wr(3'd2, 16'h0001);
      for (int k = 0; k < 3; k++) begin
         dma_ack = 1'b1; dev_in = 16'h0000;
         #1; chk("wr_dev_out", dev_out, wr_words[k]);
         cyc();
      end
      #1; chk("wr_dev_ack_empty", {15'd0, dev_ack}, 16'h0000);
      chk("wr_dev_out_empty", dev_out, 16'h0000);

      // End of operation and interrupt
      bus_wr(3'd2, 16'h0000);
      bus_wr(3'd2, 16'h000D);
      dma_end_flag = 1'b1; cyc();
      chk("end_rqst", {15'd0, dma_rqst}, 16'h0000);
      chk("end_irq", {15'd0, irq}, 16'h0001);
      bus_rd(3'd3, v); chk("end_status", v, 16'h8800);
      bus_wr(3'd3, 16'h8000);
      #1; chk("end_irq_clr", {15'd0, irq}, 16'h0000);

      // Abort keeps FIFO; reset mid-operation clears everything
      bus_wr(3'd2, 16'h0005);
      dma_word(16'h0A0A); dma_word(16'h0B0B);
      bus_wr(3'd2, 16'h0000);
      chk("abort_rqst", {15'd0, dma_rqst}, 16'h0000);
      bus_rd(3'd3, v); chk("abort_fifo_kept", v, 16'h0002);
      bus_wr(3'd2, 16'h0005);
      dma_word(16'h0C0C);
      reset = 1'b1; cyc();
      chk("rr_rqst", {15'd0, dma_rqst}, 16'h0000);
      chk("rr_rd_wr", {15'd0, dma_rd_wr}, 16'h0000);
      chk("rr_dev_ack", {15'd0, dev_ack}, 16'h0000);
      chk("rr_start_addr", dma_start_address, 16'h0000);
      bus_rd(3'd3, v); chk("rr_status", v, 16'h0800);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         logic [2:0] ridx;
         ridx = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) ridx = 3'd4;
         per_en   = 1'($urandom_range(0, 1));
         per_addr = 14'h0080 + {11'd0, ridx};
         if ($urandom_range(0, 15) == 0) per_addr = 14'($urandom());
         per_we   = 2'($urandom_range(0, 3));
         per_din  = 16'($urandom());
         if (ridx == 3'd2 && $urandom_range(0, 3) != 0) per_din[4] = 1'b0;
         dev_in       = 16'($urandom());
         dma_ack      = ($urandom_range(0, 2) != 0);
         dma_end_flag = ($urandom_range(0, 59) == 0);
         reset        = ($urandom_range(0, 299) == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
